atm_db_arbiter: RTL and testbench
=================================

ATM_DB_ARBITER -- requirements
Module: atm_db_arbiter

Interface
REQ-001 Parameters: balance_width, default 20, balance word width; card_width, default 3, card index width; users_num, default 7, number of valid accounts.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  2  per-terminal transaction request; bit p = terminal p.
REQ-005 op  input  4  2 bits per terminal: 00 withdraw, 01 deposit, 10 inquiry, 11 invalid.
REQ-006 card_number  input  2*card_width  account index per terminal.
REQ-007 value  input  2*balance_width  amount per terminal.
REQ-008 busy  output  2  one-hot; terminal whose transaction is in progress.
REQ-009 done  output  2  one-cycle completion pulse to the served terminal.
REQ-010 rsp_balance  output  balance_width  result balance; valid only while any done bit is high.
REQ-011 rsp_error  output  1  transaction rejected; valid only while any done bit is high.
REQ-012 mem_addr  output  card_width  balance RAM address.
REQ-013 mem_rd_en  output  1  RAM read strobe.
REQ-014 mem_rdata  input  balance_width  RAM read data; valid in the cycle after mem_rd_en.
REQ-015 mem_wr_en  output  1  RAM write strobe.
REQ-016 mem_wdata  output  balance_width  RAM write data.

Function
REQ-017 FSM states: IDLE, RD, CAP, EXEC, DONE; exactly one transaction in flight at a time.
REQ-018 IDLE: with any eligible req, select a terminal by round-robin, latch its op, card_number and value, and set busy.
REQ-019 Arbitration: rr pointer selects the winner when both terminals request. After each done, the pointer moves to the other terminal.
REQ-020 Eligibility: req[p] is ignored in the first IDLE cycle after done[p]. This masks the requester's one-cycle deassert delay.
REQ-021 Early reject: in IDLE, card_number >= users_num or op == 11 goes directly to DONE with rsp_error=1 and rsp_balance=0. No memory access; done in the cycle after acceptance.
REQ-022 RD: mem_rd_en=1, mem_addr = latched card. CAP: register mem_rdata as bal.
REQ-023 EXEC, withdraw: if value <= bal, then mem_wr_en=1 and mem_wdata = bal - value. Otherwise no write and error. value == bal is legal and yields 0.
REQ-024 EXEC, deposit: compute bal + value at balance_width+1 bits. On carry out, no write and error; otherwise write the truncated sum.
REQ-025 EXEC, inquiry: no write, no error.
REQ-026 DONE: done[p]=1 for exactly one cycle. rsp_balance = written value on success, bal on inquiry or insufficient funds/overflow, 0 on early reject. Then busy clears and the FSM returns to IDLE.
REQ-027 Latency: req accepted in cycle 0 → done in cycle 4 (memory path) or cycle 1 (early reject).
REQ-028 Inputs are latched at acceptance. Changes to req, op, card_number or value after acceptance do not affect the transaction in flight.
REQ-029 mem_rd_en and mem_wr_en are never high in the same cycle. At most one write occurs per transaction, only in EXEC.
REQ-030 done, busy and the mem strobes are 0 in all states not listed above. done and busy are never non-zero for both bits at once.

Reset
REQ-031 While rst=1 at a clock edge: FSM=IDLE, rr pointer=terminal 0, eligibility masks cleared.
REQ-032 Also while rst=1: busy=0, done=0, rsp_balance=0, rsp_error=0, mem_addr=0, mem_rd_en=0, mem_wr_en=0, mem_wdata=0.
REQ-033 Reset mid-transaction aborts it with no memory write and no done pulse, including reset asserted in the EXEC cycle.

Verification
REQ-034 RAM[0]=500; terminal 0 withdraw card 0, value 100 → done[0] in cycle 4, rsp_balance=400, rsp_error=0, RAM[0]=400.
REQ-035 RAM[2]=50; terminal 1 withdraw card 2, value 51 → rsp_error=1, rsp_balance=50, no mem_wr_en. Repeat with value 50 → rsp_balance=0, RAM[2]=0.
REQ-036 RAM[1]=1048575; deposit card 1, value 1 → rsp_error=1, no write. Deposit value 0 → success, rsp_balance=1048575.
REQ-037 Both req high from reset, both deposit 10 to card 3, RAM[3]=0 → terminal 0 served first, then terminal 1. Final RAM[3]=20; done pulses 5 cycles apart with the intervening IDLE cycle.
REQ-038 Terminal 0 req with card_number 7 or op 11 → done[0] in cycle 1, rsp_error=1, rsp_balance=0, no mem_rd_en.
REQ-039 Deposit accepted, rst=1 during the EXEC cycle → no mem_wr_en, no done, all outputs 0, RAM unchanged. Next request is served normally from terminal 0 priority.

Source files
------------

// File: rtl/atm_db_arbiter.sv
// -----------------------------------------------------------------------------
// atm_db_arbiter
// Two ATM terminals share one account-balance RAM. Transactions are served
// one at a time. When both terminals request, a round-robin pointer picks the
// winner. A memory transaction walks IDLE -> RD -> CAP -> EXEC -> DONE.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req[1:0]        per-terminal request (bit p = terminal p)
//   op[3:0]         2 bits per terminal: 00 withdraw, 01 deposit,
//                   10 inquiry, 11 invalid
//   card_number     card_width bits per terminal (account index)
//   value           balance_width bits per terminal (amount)
//   busy[1:0]       one-hot, terminal whose transaction is in flight
//   done[1:0]       one-cycle completion pulse to the served terminal
//   rsp_balance     result balance, valid while done != 0
//   rsp_error       transaction rejected, valid while done != 0
//   mem_addr        balance RAM address
//   mem_rd_en       RAM read strobe (data returns on mem_rdata next cycle)
//   mem_rdata       RAM read data
//   mem_wr_en       RAM write strobe
//   mem_wdata       RAM write data
// -----------------------------------------------------------------------------
module atm_db_arbiter #(
  parameter int balance_width = 20,
  parameter int card_width    = 3,
  parameter int users_num     = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req,
  input  logic [3:0]                 op,
  input  logic [2*card_width-1:0]    card_number,
  input  logic [2*balance_width-1:0] value,
  output logic [1:0]                 busy,
  output logic [1:0]                 done,
  output logic [balance_width-1:0]   rsp_balance,
  output logic                       rsp_error,
  output logic [card_width-1:0]      mem_addr,
  output logic                       mem_rd_en,
  input  logic [balance_width-1:0]   mem_rdata,
  output logic                       mem_wr_en,
  output logic [balance_width-1:0]   mem_wdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, EXEC, DONE} state_t;

  state_t                   state_reg, state_next;
  logic                     term_reg, term_next;     // terminal being served
  logic                     rr_reg, rr_next;         // preferred terminal on contention
  logic [1:0]               mask_reg, mask_next;     // terminal just finished, ignored for one IDLE cycle
  logic [1:0]               op_reg, op_next;
  logic [card_width-1:0]    card_reg, card_next;
  logic [balance_width-1:0] value_reg, value_next;
  logic [balance_width-1:0] bal_reg, bal_next;
  logic [balance_width-1:0] result_reg, result_next;
  logic                     error_reg, error_next;

  // Per-terminal views of the packed request fields
  logic [1:0]               op_t    [2];
  logic [card_width-1:0]    card_t  [2];
  logic [balance_width-1:0] value_t [2];
  logic [1:0]               reject_t;

  logic [1:0]               elig;
  logic                     winner;
  logic                     busy_any, done_any;
  logic [balance_width:0]   sum;
  logic [balance_width-1:0] diff;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_term
      assign op_t[gi]     = op[2*gi +: 2];
      assign card_t[gi]   = card_number[gi*card_width +: card_width];
      assign value_t[gi]  = value[gi*balance_width +: balance_width];
      // Unknown account or invalid opcode never touches the RAM
      assign reject_t[gi] = (op_t[gi] == 2'b11) || (32'(card_t[gi]) >= users_num);
      assign busy[gi]     = busy_any && (term_reg == 1'(gi));
      assign done[gi]     = done_any && (term_reg == 1'(gi));
    end
  endgenerate

  assign elig   = req & ~mask_reg;
  // With both eligible the rr pointer decides; otherwise the single requester wins
  assign winner = (elig == 2'b11) ? rr_reg : elig[1];

  // One extra bit keeps the deposit carry for overflow detection
  assign sum  = {1'b0, bal_reg} + {1'b0, value_reg};
  assign diff = bal_reg - value_reg;

  always_comb begin
    state_next  = state_reg;
    term_next   = term_reg;
    rr_next     = rr_reg;
    mask_next   = 2'b00;
    op_next     = op_reg;
    card_next   = card_reg;
    value_next  = value_reg;
    bal_next    = bal_reg;
    result_next = result_reg;
    error_next  = error_reg;
    busy_any    = 1'b0;
    done_any    = 1'b0;
    rsp_balance = '0;
    rsp_error   = 1'b0;
    mem_addr    = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wdata   = '0;

    case (state_reg)
      IDLE: begin
        if (|elig) begin
          term_next  = winner;
          op_next    = op_t[winner];
          card_next  = card_t[winner];
          value_next = value_t[winner];
          if (reject_t[winner]) begin
            result_next = '0;
            error_next  = 1'b1;
            state_next  = DONE;
          end else begin
            state_next  = RD;
          end
        end
      end
      RD: begin
        busy_any   = 1'b1;
        mem_rd_en  = 1'b1;
        mem_addr   = card_reg;
        state_next = CAP;
      end
      CAP: begin
        busy_any   = 1'b1;
        bal_next   = mem_rdata;
        state_next = EXEC;
      end
      EXEC: begin
        busy_any    = 1'b1;
        mem_addr    = card_reg;
        result_next = bal_reg;
        error_next  = 1'b0;
        case (op_reg)
          2'b00: begin
            if (value_reg <= bal_reg) begin
              mem_wr_en   = 1'b1;
              mem_wdata   = diff;
              result_next = diff;
            end else begin
              error_next  = 1'b1;
            end
          end
          2'b01: begin
            if (sum[balance_width]) begin
              error_next  = 1'b1;
            end else begin
              mem_wr_en   = 1'b1;
              mem_wdata   = sum[balance_width-1:0];
              result_next = sum[balance_width-1:0];
            end
          end
          default: ;  // inquiry: report the balance, no write
        endcase
        state_next = DONE;
      end
      DONE: begin
        busy_any    = 1'b1;
        done_any    = 1'b1;
        rsp_balance = result_reg;
        rsp_error   = error_reg;
        rr_next     = ~term_reg;
        mask_next   = term_reg ? 2'b10 : 2'b01;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Reset silences every output in the same cycle, so a reset that lands
    // in EXEC cannot let the write strobe through.
    if (rst) begin
      busy_any    = 1'b0;
      done_any    = 1'b0;
      rsp_balance = '0;
      rsp_error   = 1'b0;
      mem_addr    = '0;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_wdata   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      term_reg   <= 1'b0;
      rr_reg     <= 1'b0;
      mask_reg   <= 2'b00;
      op_reg     <= 2'b00;
      card_reg   <= '0;
      value_reg  <= '0;
      bal_reg    <= '0;
      result_reg <= '0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      term_reg   <= term_next;
      rr_reg     <= rr_next;
      mask_reg   <= mask_next;
      op_reg     <= op_next;
      card_reg   <= card_next;
      value_reg  <= value_next;
      bal_reg    <= bal_next;
      result_reg <= result_next;
      error_reg  <= error_next;
    end
  end

endmodule

// File: tb/tb_atm_db_arbiter.sv
// -----------------------------------------------------------------------------
// tb_atm_db_arbiter
// Scoreboard bench: the stimulus process predicts each response from a
// behavioural account model and queues it; a negedge monitor pops and compares
// whenever done is presented. Directed scenarios come first, then random rounds.
// -----------------------------------------------------------------------------
module tb_atm_db_arbiter;

  localparam int BW    = 20;
  localparam int CW    = 3;
  localparam int USERS = 7;
  localparam longint MAXB = (longint'(1) << BW) - 1;

  logic              clk;
  logic              rst;
  logic [1:0]        req;
  logic [3:0]        op;
  logic [2*CW-1:0]   card_number;
  logic [2*BW-1:0]   value;
  logic [1:0]        busy;
  logic [1:0]        done;
  logic [BW-1:0]     rsp_balance;
  logic              rsp_error;
  logic [CW-1:0]     mem_addr;
  logic              mem_rd_en;
  logic [BW-1:0]     mem_rdata;
  logic              mem_wr_en;
  logic [BW-1:0]     mem_wdata;

  atm_db_arbiter #(.balance_width(BW), .card_width(CW), .users_num(USERS)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .card_number(card_number),
    .value(value), .busy(busy), .done(done), .rsp_balance(rsp_balance),
    .rsp_error(rsp_error), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Balance RAM with registered read
  logic [BW-1:0] ram [8] = '{20'd500, 20'd1048575, 20'd50, 20'd0,
                             20'd777, 20'd1000, 20'd123456, 20'd42};
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    int     term;
    longint bal;
    longint err;
    int     rd;
    int     wr;
    int     lat;
  } exp_t;

  typedef struct {
    string  name;
    longint act;
    longint exp;
  } cq_t;

  exp_t   sb [$];
  cq_t    cq [$];
  longint mbal [8];
  int     rr_m;
  int     checks;
  int     errors;

  // Reference model: account rules in plain arithmetic
  function automatic exp_t model(input int term, input int o, input int c, input longint v);
    exp_t   e;
    longint b;
    e.term = term; e.bal = 0; e.err = 0; e.rd = 0; e.wr = 0; e.lat = 1;
    if (c >= USERS || o == 3) begin
      e.err = 1;
      return e;
    end
    e.rd  = 1;
    e.lat = 4;
    b = mbal[c];
    if (o == 0) begin
      if (v <= b) begin mbal[c] = b - v; e.bal = b - v; e.wr = 1; end
      else begin e.bal = b; e.err = 1; end
    end else if (o == 1) begin
      if (b + v > MAXB) begin e.bal = b; e.err = 1; end
      else begin mbal[c] = b + v; e.bal = b + v; e.wr = 1; end
    end else begin
      e.bal = b;
    end
    return e;
  endfunction

  // Stimulus-side checks are handed to the monitor, which owns the counters
  task automatic post(input string n, input longint a, input longint e);
    cq_t c;
    c.name = n; c.act = a; c.exp = e;
    cq.push_back(c);
  endtask

  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", n, a, e);
    end
  endtask

  // Monitor
  int rd_cnt, wr_cnt, ovl_cnt;
  always @(negedge clk) begin
    exp_t e;
    cq_t  c;
    while (cq.size() > 0) begin
      c = cq.pop_front();
      chk(c.name, c.act, c.exp);
    end
    if (rst) begin
      rd_cnt = 0; wr_cnt = 0; ovl_cnt = 0;
    end else begin
      if (mem_rd_en) rd_cnt++;
      if (mem_wr_en) wr_cnt++;
      if (mem_rd_en && mem_wr_en) ovl_cnt++;
      if (done != 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", longint'(done), 0);
        end else begin
          e = sb.pop_front();
          chk("done",        longint'(done),        longint'(1) << e.term);
          chk("busy",        longint'(busy),        longint'(1) << e.term);
          chk("rsp_balance", longint'(rsp_balance), e.bal);
          chk("rsp_error",   longint'(rsp_error),   e.err);
          chk("rd_count",    rd_cnt,                e.rd);
          chk("wr_count",    wr_cnt,                e.wr);
          chk("rd_wr_overlap", ovl_cnt,             0);
          $display("txn term=%0d bal=%0d err=%0d", e.term, rsp_balance, rsp_error);
        end
        rd_cnt = 0; wr_cnt = 0; ovl_cnt = 0;
      end
    end
  end

  task automatic set_fields(input int p, input int o, input int c, input longint v);
    op[2*p +: 2]           = 2'(o);
    card_number[p*CW +: CW] = CW'(c);
    value[p*BW +: BW]      = BW'(v);
  endtask

  // One arbitration round: one or both terminals request together; each
  // terminal drops its request two cycles after its done pulse.
  task automatic run_round(input logic [1:0] who, input int o0, input int o1,
                           input int c0, input int c1, input longint v0, input longint v1);
    exp_t   e0, e1;
    int     first, second, k;
    int     oo [2];
    int     cc [2];
    longint vv [2];
    int     dcyc [2];
    int     drop [2];
    logic [1:0] pend;
    oo[0] = o0; oo[1] = o1; cc[0] = c0; cc[1] = c1; vv[0] = v0; vv[1] = v1;
    e1 = '{0, 0, 0, 0, 0, 0};
    if (who == 2'b11) begin first = rr_m; second = 1 - rr_m; end
    else begin first = who[1] ? 1 : 0; second = -1; end
    e0 = model(first, oo[first], cc[first], vv[first]);
    sb.push_back(e0);
    if (second >= 0) begin
      e1 = model(second, oo[second], cc[second], vv[second]);
      sb.push_back(e1);
    end
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) if (who[p]) set_fields(p, oo[p], cc[p], vv[p]);
    req = who; pend = who;
    drop[0] = 0; drop[1] = 0; dcyc[0] = -1; dcyc[1] = -1;
    k = 0;
    while (req != 2'b00 && k < 60) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++)
        if (done[p] && pend[p]) begin pend[p] = 1'b0; dcyc[p] = k; drop[p] = 2; end
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (drop[p] > 0) begin
          drop[p]--;
          if (drop[p] == 0) begin
            req[p] = 1'b0;
            set_fields(p, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                       longint'($urandom_range(0, 1048575)));
          end
        end
      end
      k++;
    end
    if (req != 2'b00) begin
      post("round_timeout", longint'(req), 0);
      req = 2'b00;
    end
    post("latency_first", dcyc[first], e0.lat);
    if (second >= 0) post("latency_second", dcyc[second], e0.lat + 1 + e1.lat);
    rr_m = (second >= 0) ? first : 1 - first;
  endtask

  function automatic int rand_op();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 4) return 0;
    if (r < 7) return 1;
    if (r < 9) return 2;
    return 3;
  endfunction

  function automatic longint rand_val();
    if ($urandom_range(0, 3) == 0) return longint'($urandom_range(0, 1048575));
    return longint'($urandom_range(0, 600));
  endfunction

  initial begin
    logic [1:0] who;
    checks = 0; errors = 0; rr_m = 0;
    rd_cnt = 0; wr_cnt = 0; ovl_cnt = 0;
    mbal[0] = 500; mbal[1] = 1048575; mbal[2] = 50; mbal[3] = 0;
    mbal[4] = 777; mbal[5] = 1000;    mbal[6] = 123456; mbal[7] = 42;
    rst = 1'b1; req = 2'b00; op = '0; card_number = '0; value = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    post("reset_outputs", longint'({busy, done, rsp_balance, rsp_error, mem_addr,
                                    mem_rd_en, mem_wr_en, mem_wdata}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Withdraw 100 from 500
    run_round(2'b01, 0, 0, 0, 0, 100, 0);
    post("ram0_after_withdraw", longint'(ram[0]), 400);
    // Insufficient funds, then exact balance
    run_round(2'b10, 0, 0, 0, 2, 0, 51);
    post("ram2_unchanged", longint'(ram[2]), 50);
    run_round(2'b10, 0, 0, 0, 2, 0, 50);
    post("ram2_zero", longint'(ram[2]), 0);
    // Deposit overflow, then deposit of zero at the maximum balance
    run_round(2'b01, 1, 0, 1, 0, 1, 0);
    run_round(2'b10, 0, 1, 0, 1, 0, 0);
    post("ram1_max", longint'(ram[1]), 1048575);
    // Early rejects: unknown card, invalid opcode
    run_round(2'b01, 0, 0, 7, 0, 5, 0);
    run_round(2'b01, 3, 0, 0, 0, 5, 0);

    // Reset landing in the EXEC cycle of a deposit
    @(posedge clk); #1;
    set_fields(1, 1, 4, 5);
    req = 2'b10;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    post("reset_in_exec_outputs", longint'({busy, done, rsp_balance, rsp_error, mem_addr,
                                            mem_rd_en, mem_wr_en, mem_wdata}), 0);
    @(posedge clk); #1;
    req = 2'b00; rst = 1'b0;
    rr_m = 0;
    post("ram4_after_abort", longint'(ram[4]), 777);

    // Both terminals deposit 10 into card 3 right after reset
    run_round(2'b11, 1, 1, 3, 3, 10, 10);
    post("ram3_both", longint'(ram[3]), 20);

    // Random rounds
    for (int r = 0; r < 60; r++) begin
      who = 2'($urandom_range(1, 3));
      run_round(who, rand_op(), rand_op(), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), rand_val(), rand_val());
    end

    for (int i = 0; i < 8; i++) post($sformatf("ram_final_%0d", i), longint'(ram[i]), mbal[i]);
    post("scoreboard_leftover", longint'(sb.size()), 0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
